// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_scan_ctrl_pkg;

    localparam int          NUM_DIGITS      = 4;
    localparam logic [7:0]  SEG_OFF         = 8'hFF;
    localparam logic [3:0]  AN_OFF          = 4'hF;
    localparam int          DEF_REFRESH_DIV = 100000;
    localparam int          DEF_BLINK_SCANS = 125;

    typedef logic [3:0] nibble_t;

    // Active-low one-hot anode pattern for scan index idx.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: digit data and controls in, segment/anode pins and frame marker out.
interface seg_scan_ctrl_if;
    import seg_scan_ctrl_pkg::*;

    logic [15:0] digits;
    logic [3:0]  blank_en;
    logic [3:0]  blink_en;
    logic [3:0]  dp_en;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    modport master (
        output digits, blank_en, blink_en, dp_en,
        input  seg, an, frame_start
    );

    modport slave (
        input  digits, blank_en, blink_en, dp_en,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg_scan_ctrl_seven_seg.sv
// BCD to active-low seven-segment decoder; bit order g..a, values 10-15 are blank.
module seven_seg
    import seg_scan_ctrl_pkg::*;
(
    input  nibble_t    bcd_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = 7'h7F;
        case (bcd_i)
            4'd0: seg_n_o = 7'h40;
            4'd1: seg_n_o = 7'h79;
            4'd2: seg_n_o = 7'h24;
            4'd3: seg_n_o = 7'h30;
            4'd4: seg_n_o = 7'h19;
            4'd5: seg_n_o = 7'h12;
            4'd6: seg_n_o = 7'h02;
            4'd7: seg_n_o = 7'h78;
            4'd8: seg_n_o = 7'h00;
            4'd9: seg_n_o = 7'h10;
            default: seg_n_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with frame-coherent shadow registers,
// per-digit blank/blink/dp overrides and registered anode/segment outputs.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int BLINK_SCANS = DEF_BLINK_SCANS
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [BCN_W-1:0] BCN_MAX = BCN_W'(BLINK_SCANS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [BCN_W-1:0] bcnt_q, bcnt_d;
    logic             phase_q, phase_d;
    logic [15:0]      sh_dig_q, sh_dig_d;
    logic [3:0]       sh_blank_q, sh_blank_d;
    logic [3:0]       sh_blink_q, sh_blink_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_start_q, frame_start_d;

    nibble_t          nib [NUM_DIGITS];
    nibble_t          cur_nib;
    logic [6:0]       dec_seg;
    logic             cnt_wrap;
    logic             frame_wrap;
    logic             dark;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib[gi] = sh_dig_q[4*gi +: 4];
    end

    assign cur_nib = nib[idx_q];

    seven_seg u_dec (
        .bcd_i   (cur_nib),
        .seg_n_o (dec_seg)
    );

    assign cnt_wrap   = (cnt_q == CNT_MAX);
    assign frame_wrap = cnt_wrap && (idx_q == 2'd3);
    assign dark       = sh_blank_q[idx_q] | (sh_blink_q[idx_q] & phase_q);

    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        bcnt_d        = bcnt_q;
        phase_d       = phase_q;
        sh_dig_d      = sh_dig_q;
        sh_blank_d    = sh_blank_q;
        sh_blink_d    = sh_blink_q;
        sh_dp_d       = sh_dp_q;
        frame_start_d = frame_wrap;
        an_d          = anode_sel(idx_q);
        seg_d         = dark ? SEG_OFF : {~sh_dp_q[idx_q], dec_seg};

        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        // Shadows and blink phase move together so a frame is never torn.
        if (frame_wrap) begin
            sh_dig_d   = bus.digits;
            sh_blank_d = bus.blank_en;
            sh_blink_d = bus.blink_en;
            sh_dp_d    = bus.dp_en;
            if (bcnt_q == BCN_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BCN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            bcnt_q        <= '0;
            phase_q       <= 1'b0;
            sh_dig_q      <= '0;
            sh_blank_q    <= 4'hF;
            sh_blink_q    <= '0;
            sh_dp_q       <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            bcnt_q        <= bcnt_d;
            phase_q       <= phase_d;
            sh_dig_q      <= sh_dig_d;
            sh_blank_q    <= sh_blank_d;
            sh_blink_q    <= sh_blink_d;
            sh_dp_q       <= sh_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-cycle expected an/seg/frame_start
// entries are queued with each frame's stimulus and drained one per clock.
module tb_seg_scan_ctrl;
    import seg_scan_ctrl_pkg::*;

    localparam int RD = 4;
    localparam int BS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .REFRESH_DIV (RD),
        .BLINK_SCANS (BS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fs;
        int         frame;
        int         slot;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   frame_no;

    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_cycle(input logic [3:0] an, input logic [7:0] seg, input logic fs,
                              input int frame, input int slot);
        exp_t e;
        e.an = an; e.seg = seg; e.fs = fs; e.frame = frame; e.slot = slot;
        sb.push_back(e);
    endtask

    // A frame lit from given controls; blink phase derives from the frame number.
    task automatic push_frame(input logic [15:0] dig, input logic [3:0] blank,
                              input logic [3:0] blink, input logic [3:0] dp, input logic force_dark);
        logic [3:0] one;
        logic [3:0] an;
        logic [7:0] seg;
        logic       phase;
        one   = 4'b0001;
        phase = (((frame_no - 1) / BS) % 2) == 1;
        for (int d = 0; d < 4; d++) begin
            an = ~(one << d);
            if (force_dark || blank[d] || (blink[d] && phase))
                seg = 8'hFF;
            else
                seg = {~dp[d], ref_glyph(dig[4*d +: 4])};
            for (int c = 0; c < RD; c++)
                push_cycle(an, seg, (d == 3) && (c == RD - 1), frame_no, d * RD + c);
        end
        $display("frame %0d queued: digits=%04h blank=%b blink=%b dp=%b phase=%0d dark=%0d",
                 frame_no, dig, blank, blink, dp, phase, force_dark);
        frame_no++;
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("f%0d.s%0d an", e.frame, e.slot), 32'(bus.an), 32'(e.an));
                check($sformatf("f%0d.s%0d seg", e.frame, e.slot), 32'(bus.seg), 32'(e.seg));
                check($sformatf("f%0d.s%0d frame_start", e.frame, e.slot),
                      32'(bus.frame_start), 32'(e.fs));
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.digits   = 16'h0000;
        bus.blank_en = 4'h0;
        bus.blink_en = 4'h0;
        bus.dp_en    = 4'h0;
        frame_no     = 1;

        // Reset hold, then dark first frame and the 1234 scan order.
        for (int i = 0; i < 3; i++) push_cycle(AN_OFF, SEG_OFF, 1'b0, 0, i);
        drain(3);
        bus.digits = 16'h1234;
        rst        = 1'b0;
        push_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
        push_frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        drain(32);

        // Tearing: change digits while digit 1 is being scanned.
        push_frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        drain(5);
        bus.digits = 16'h5678;
        drain(11);

        push_frame(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0);
        bus.digits   = 16'h0008;
        bus.blink_en = 4'b0001;
        drain(16);

        // Blink on digit 0 across two full-frame half periods.
        for (int f = 0; f < 4; f++) begin
            push_frame(16'h0008, 4'h0, 4'b0001, 4'h0, 1'b0);
            drain(16);
        end
        push_frame(16'h0008, 4'h0, 4'b0001, 4'h0, 1'b0);
        bus.digits   = 16'h0200;
        bus.blink_en = 4'h0;
        bus.dp_en    = 4'b0100;
        drain(16);

        // Decimal point, non-BCD nibble, then blank override.
        push_frame(16'h0200, 4'h0, 4'h0, 4'b0100, 1'b0);
        bus.digits = 16'h0A00;
        drain(16);
        push_frame(16'h0A00, 4'h0, 4'h0, 4'b0100, 1'b0);
        bus.blank_en = 4'b0100;
        drain(16);
        push_frame(16'h0A00, 4'b0100, 4'h0, 4'b0100, 1'b0);
        drain(16);

        // Reset while digit 2 is selected.
        push_frame(16'h0A00, 4'b0100, 4'h0, 4'b0100, 1'b0);
        drain(9);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 2; i++) push_cycle(AN_OFF, SEG_OFF, 1'b0, 0, 10 + i);
        drain(2);
        rst          = 1'b0;
        bus.digits   = 16'h1234;
        bus.blank_en = 4'h0;
        bus.dp_en    = 4'h0;
        frame_no     = 1;
        push_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
        push_frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        drain(32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
